// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : ahb_slave_mem
// Brief   : AHB-style slave with a 2^AW x 32-bit register memory, configurable
//           wait states and a two-cycle ERROR response outside the window.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_slave_mem #(
    parameter logic [31:0] BASE = 32'h8000_0000,
    parameter int          AW   = 8,
    parameter int          WAIT = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WAITST = 3'd1;
    localparam logic [2:0] c_DONE   = 3'd2;
    localparam logic [2:0] c_ERR1   = 3'd3;
    localparam logic [2:0] c_ERR2   = 3'd4;

    localparam logic [1:0] c_OKAY  = 2'b00;
    localparam logic [1:0] c_ERROR = 2'b01;

    localparam int         c_DEPTH       = 2 ** AW;
    localparam int         c_WAIT_LAST_I = (WAIT > 0) ? WAIT - 1 : 0;
    localparam logic [1:0] c_WAIT_LAST   = c_WAIT_LAST_I[1:0];

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [1:0]    r_cnt;
    logic          r_write;
    logic          r_hit;
    logic [AW-1:0] r_idx;
    logic          r_hreadyout;
    logic [1:0]    r_hresp;
    logic [31:0]   r_hrdata;
    logic [31:0]   r_mem [c_DEPTH];

    logic          w_accept;
    logic          w_hit;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_rd_write;
    logic          w_rd_load;
    logic          w_wr_done;
    logic          w_unused;

    assign w_accept = Hreadyin && r_hreadyout && Htrans[1];
    assign w_hit    = (Haddr[31:AW] == BASE[31:AW]);
    assign w_idx    = Haddr[AW-1:0];
    assign w_unused = Htrans[0];

    // A read entering DONE straight from an address phase uses the live bus;
    // one leaving WAITST uses the latched transfer.
    assign w_rd_idx   = w_accept ? w_idx  : r_idx;
    assign w_rd_write = w_accept ? Hwrite : r_write;
    assign w_wr_done  = (r_state == c_DONE) && r_write && r_hit;
    assign w_rd_load  = (w_next == c_DONE) && !w_rd_write;

    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_WAITST: w_next = (r_cnt == c_WAIT_LAST) ? c_DONE : c_WAITST;
            c_ERR1:   w_next = c_ERR2;
            default: begin
                if (w_accept) begin
                    if (!w_hit)
                        w_next = c_ERR1;
                    else if (WAIT > 0)
                        w_next = c_WAITST;
                    else
                        w_next = c_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 2'd0;
            r_write     <= 1'b0;
            r_hit       <= 1'b0;
            r_idx       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= c_OKAY;
            r_hrdata    <= 32'h0;
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= Hwrite;
                r_idx   <= w_idx;
                r_hit   <= w_hit;
            end
            r_cnt       <= (r_state == c_WAITST && w_next == c_WAITST) ? r_cnt + 2'd1 : 2'd0;
            r_hreadyout <= (w_next != c_WAITST) && (w_next != c_ERR1);
            r_hresp     <= (w_next == c_ERR1 || w_next == c_ERR2) ? c_ERROR : c_OKAY;
            // Read-after-write to the same location forwards the completing data.
            if (w_rd_load)
                r_hrdata <= (w_wr_done && r_idx == w_rd_idx) ? Hwdata : r_mem[w_rd_idx];
            else
                r_hrdata <= 32'h0;
            if (w_wr_done)
                r_mem[r_idx] <= Hwdata;
        end
    end

    assign Hreadyout = r_hreadyout;
    assign Hresp     = r_hresp;
    assign Hrdata    = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_slave_mem
// Brief   : Scoreboard bench for ahb_slave_mem, WAIT=0 and WAIT=2 instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem;

    localparam logic [1:0]  c_IDLE = 2'b00;
    localparam logic [1:0]  c_BUSY = 2'b01;
    localparam logic [1:0]  c_NSEQ = 2'b10;
    localparam logic [1:0]  c_SEQ  = 2'b11;
    localparam logic [31:0] c_BASE = 32'h8000_0000;
    localparam logic [31:0] c_SIZE = 32'd256;

    typedef struct packed {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic        hclk     = 1'b0;
    logic        hreset   = 1'b1;
    logic        hwrite   = 1'b0;
    logic        hreadyin = 1'b1;
    logic        sel      = 1'b0;
    logic [1:0]  htrans   = 2'b00;
    logic [31:0] haddr    = 32'h0;
    logic [31:0] hwdata   = 32'h0;

    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;
    logic [31:0] rdata0, rdata2;
    logic [1:0]  w_htrans0, w_htrans2;
    logic        w_rdy;
    logic [1:0]  w_resp;
    logic [31:0] w_rdata;

    exp_t        expq[$];
    logic [31:0] model [256];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    assign w_htrans0 = sel ? c_IDLE : htrans;
    assign w_htrans2 = sel ? htrans : c_IDLE;
    assign w_rdy     = sel ? rdy2   : rdy0;
    assign w_resp    = sel ? resp2  : resp0;
    assign w_rdata   = sel ? rdata2 : rdata0;

    ahb_slave_mem #(.BASE(c_BASE), .AW(8), .WAIT(0)) u_dut0 (
        .Hclk(hclk), .Hreset(hreset), .Hwrite(hwrite), .Hreadyin(hreadyin),
        .Htrans(w_htrans0), .Haddr(haddr), .Hwdata(hwdata),
        .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rdata0)
    );

    ahb_slave_mem #(.BASE(c_BASE), .AW(8), .WAIT(2)) u_dut2 (
        .Hclk(hclk), .Hreset(hreset), .Hwrite(hwrite), .Hreadyin(hreadyin),
        .Htrans(w_htrans2), .Haddr(haddr), .Hwdata(hwdata),
        .Hreadyout(rdy2), .Hresp(resp2), .Hrdata(rdata2)
    );

    always #5 hclk = ~hclk;

    function automatic int cur_wait();
        return sel ? 2 : 0;
    endfunction

    // Reference: a transfer either lands in the 256-word window or errors.
    function automatic void push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
        int off;
        exp_t e;
        if (a >= c_BASE && a < c_BASE + c_SIZE) begin
            off = int'(a - c_BASE);
            for (int i = 0; i < cur_wait(); i++) begin
                e = '{1'b0, 2'b00, 32'h0};
                expq.push_back(e);
            end
            e = '{1'b1, 2'b00, (w ? 32'h0 : model[off])};
            expq.push_back(e);
            if (w) model[off] = d;
        end else begin
            e = '{1'b0, 2'b01, 32'h0};
            expq.push_back(e);
            e = '{1'b1, 2'b01, 32'h0};
            expq.push_back(e);
        end
    endfunction

    task automatic do_reset();
        hreset   = 1'b1;
        htrans   = c_IDLE;
        hreadyin = 1'b1;
        expq.delete();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic w, input logic [1:0] t, input logic [31:0] d);
        int n;
        haddr    = a;
        hwrite   = w;
        htrans   = t;
        hreadyin = 1'b1;
        n        = 0;
        @(negedge hclk);
        while (w_rdy !== 1'b1) begin
            n++;
            if (n > 16) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout addr=%h: got hreadyout=%b, required 1 within 16 cycles", a, w_rdy);
                htrans = c_IDLE;
                return;
            end
            @(negedge hclk);
        end
        @(posedge hclk);
        push_exp(a, w, d);
        #1;
        hwdata = d;
        htrans = c_IDLE;
    endtask

    task automatic gap();
        int k;
        k        = $urandom_range(0, 2);
        hreadyin = 1'b1;
        case (k)
            0:       htrans = c_IDLE;
            1:       htrans = c_BUSY;
            default: begin
                htrans   = c_NSEQ;
                hreadyin = 1'b0;
            end
        endcase
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        @(posedge hclk);
        #1;
        htrans   = c_IDLE;
        hreadyin = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0) begin
            n++;
            if (n > 64) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain_timeout: got %0d responses outstanding, required 0", expq.size());
                expq.delete();
                break;
            end
            @(posedge hclk);
        end
        #1;
    endtask

    task automatic random_traffic(input int nbursts);
        logic [31:0] a;
        logic        w;
        int          len, kind, ng;
        for (int b = 0; b < nbursts; b++) begin
            kind = $urandom_range(0, 99);
            if (kind < 70)
                a = c_BASE + 32'($urandom_range(0, 255));
            else if (kind < 85)
                a = c_BASE + 32'($urandom_range(252, 255));
            else
                a = $urandom;
            w   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++)
                beat(a + 32'(i), w, (i == 0) ? c_NSEQ : c_SEQ, $urandom);
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++)
                gap();
        end
    endtask

    // Monitor: every non-reset cycle is either a queued data-phase cycle or idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            cyc++;
            if (!hreset) begin
                if (expq.size() > 0)
                    e = expq.pop_front();
                else
                    e = '{1'b1, 2'b00, 32'h0};
                n_vec++;
                if (w_rdy !== e.rdy || w_resp !== e.resp || w_rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL cycle%0d dut_wait%0d: got rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
                             cyc, cur_wait(), w_rdy, w_resp, w_rdata, e.rdy, e.resp, e.rdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single write then read
        beat(32'h8000_0001, 1'b1, c_NSEQ, 32'h0000_00A3); drain();
        beat(32'h8000_0001, 1'b0, c_NSEQ, 32'h0);         drain();

        // Incrementing bursts, WAIT=0
        for (int i = 0; i < 4; i++)
            beat(c_BASE + 32'(i), 1'b1, (i == 0) ? c_NSEQ : c_SEQ, 32'h11 * 32'(i + 1));
        for (int i = 0; i < 4; i++)
            beat(c_BASE + 32'(i), 1'b0, (i == 0) ? c_NSEQ : c_SEQ, 32'h0);
        drain();

        // Read immediately after write to the same location
        beat(32'h8000_0010, 1'b1, c_NSEQ, 32'h5A);
        beat(32'h8000_0010, 1'b0, c_NSEQ, 32'h0);
        drain();

        // Misses: read, write, then check the aliased in-window index
        beat(32'h8000_01A2, 1'b0, c_NSEQ, 32'h0);         drain();
        beat(32'h8000_01A2, 1'b1, c_NSEQ, 32'hDEAD_BEEF); drain();
        beat(32'h8000_00A2, 1'b0, c_NSEQ, 32'h0);         drain();

        // Burst crossing the top of the window
        for (int i = 0; i < 4; i++)
            beat(32'h8000_00FE + 32'(i), 1'b1, (i == 0) ? c_NSEQ : c_SEQ, 32'hF0 + 32'(i));
        drain();
        beat(32'h8000_00FE, 1'b0, c_NSEQ, 32'h0);
        beat(32'h8000_00FF, 1'b0, c_SEQ,  32'h0);
        drain();

        random_traffic(150);
        drain();

        // WAIT=2 instance
        sel = 1'b1;
        do_reset();
        beat(32'h8000_00FF, 1'b1, c_NSEQ, 32'h0000_CAFE); drain();
        beat(32'h8000_0100, 1'b0, c_NSEQ, 32'h0);         drain();
        beat(32'h8000_00FF, 1'b0, c_NSEQ, 32'h0);         drain();

        // Reset lands in the first wait-state cycle of a write
        beat(32'h8000_0005, 1'b1, c_NSEQ, 32'h77);
        do_reset();
        beat(32'h8000_0005, 1'b0, c_NSEQ, 32'h0);         drain();

        random_traffic(100);
        drain();
        repeat (2) @(posedge hclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
